// File: rtl/isqrt_iter.sv
// Iterative restoring integer square root, one result bit per cycle, start/ack handshake.
// Optional round-half-up result mode is compiled in with `define ISQRT_ROUND_EN.
module isqrt_iter #(
    parameter int WIDTH = 32,
    localparam int RW = WIDTH / 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] x_bi,
`ifdef ISQRT_ROUND_EN
    input  logic             round_i,
`endif
    input  logic             ack_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [RW-1:0]    y_bo,
    output logic [RW:0]      rem_bo,
    output logic [1:0]       state_o
);

    localparam int CW = (RW > 1) ? $clog2(RW) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_ROUND = 2'd3
    } state_t;

    // Handshake: an operation is accepted on a rising edge where ready_o (IDLE)
    // or valid_o & ack_i (DONE) is high together with start_i; a result is
    // consumed on a rising edge where valid_o & ack_i are both high.
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_x;
    logic [RW-1:0]    r_root;
    logic [RW+1:0]    r_rem;
    logic [CW-1:0]    r_cnt;
    logic [RW-1:0]    r_y;
    logic [RW:0]      r_rem_o;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_load_floor;
    logic [RW+1:0]    w_rem_sh;
    logic [RW+1:0]    w_trial;
    logic [RW+1:0]    w_rem_nxt;
    logic [RW-1:0]    w_root_nxt;
    logic             w_ge;

`ifdef ISQRT_ROUND_EN
    logic             r_round;
    logic             w_load_round;
    logic [RW-1:0]    w_y_round;
`endif

    // The remainder never exceeds RW bits before the shift, so the top bits
    // shifted out here are always zero.
    assign w_rem_sh   = (r_rem << 2) | {{RW{1'b0}}, r_x[WIDTH-1 -: 2]};
    assign w_trial    = {r_root, 2'b01};
    assign w_ge       = (w_rem_sh >= w_trial);
    assign w_rem_nxt  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign w_root_nxt = {r_root[RW-2:0], w_ge};
    assign w_last     = (r_cnt == '0);

`ifdef ISQRT_ROUND_EN
    assign w_y_round = ((r_rem > {2'b00, r_root}) && !(&r_root))
                       ? (r_root + {{(RW-1){1'b0}}, 1'b1}) : r_root;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_load_floor = 1'b0;
`ifdef ISQRT_ROUND_EN
        w_load_round = 1'b0;
`endif
        case (r_state)
            S_BUSY: begin
                w_step = 1'b1;
                if (w_last) begin
`ifdef ISQRT_ROUND_EN
                    if (r_round) begin
                        w_state_nxt = S_ROUND;
                    end else begin
                        w_state_nxt  = S_DONE;
                        w_load_floor = 1'b1;
                    end
`else
                    w_state_nxt  = S_DONE;
                    w_load_floor = 1'b1;
`endif
                end
            end
            S_DONE: begin
                if (ack_i) begin
                    if (start_i) begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_BUSY;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
`ifdef ISQRT_ROUND_EN
            S_ROUND: begin
                w_state_nxt  = S_DONE;
                w_load_round = 1'b1;
            end
`endif
            // IDLE, and the unused encoding 3 when rounding is compiled out
            default: begin
                if (start_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_x     <= '0;
            r_root  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_rem_o <= '0;
`ifdef ISQRT_ROUND_EN
            r_round <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_x    <= x_bi;
                r_root <= '0;
                r_rem  <= '0;
                r_cnt  <= CW'(RW - 1);
`ifdef ISQRT_ROUND_EN
                r_round <= round_i;
`endif
            end else if (w_step) begin
                r_x    <= r_x << 2;
                r_root <= w_root_nxt;
                r_rem  <= w_rem_nxt;
                if (!w_last) r_cnt <= r_cnt - CW'(1);
            end
            if (w_load_floor) begin
                r_y     <= w_root_nxt;
                r_rem_o <= w_rem_nxt[RW:0];
            end
`ifdef ISQRT_ROUND_EN
            if (w_load_round) begin
                r_y     <= w_y_round;
                r_rem_o <= r_rem[RW:0];
            end
`endif
        end
    end

`ifdef ISQRT_ROUND_EN
    assign ready_o = (r_state == S_IDLE);
`else
    assign ready_o = (r_state == S_IDLE) || (r_state == S_ROUND);
`endif
    assign valid_o = (r_state == S_DONE);
    assign y_bo    = r_y;
    assign rem_bo  = r_rem_o;
    assign state_o = r_state;

endmodule
